// File: rtl/sw_conditioner_if.sv
// Switch conditioner bus: raw switch levels in, debounced levels and edge pulses out.
interface sw_conditioner_if #(
    parameter int N = 3
);
    logic [N-1:0] sw_in;
    logic [N-1:0] db_out;
    logic [N-1:0] rise;
    logic [N-1:0] fall;

    modport master (output sw_in, input db_out, input rise, input fall);
    modport slave  (input sw_in, output db_out, output rise, output fall);
endinterface

// File: rtl/sw_conditioner.sv
// Per-channel two-flop synchroniser followed by a run-length debouncer that emits
// registered one-cycle rise/fall pulses on the edge where the clean level updates.
module sw_conditioner #(
    parameter int N             = 3,
    parameter int STABLE_CYCLES = 500000,
    parameter int CNT_W         = 19
) (
    input  logic            clk,
    input  logic            rst_n,
    sw_conditioner_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [N-1:0]     s1;
    logic [N-1:0]     s2;
    logic [N-1:0]     db;
    logic [N-1:0]     rise_q;
    logic [N-1:0]     fall_q;
    logic [CNT_W-1:0] cnt [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '0;
            s2     <= '0;
            db     <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            s1 <= bus.sw_in;
            s2 <= s1;
            for (int unsigned i = 0; i < N; i++) begin
                rise_q[i] <= 1'b0;
                fall_q[i] <= 1'b0;
                // Any matching sample restarts the run; only an unbroken run commits.
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    db[i]     <= s2[i];
                    cnt[i]    <= '0;
                    rise_q[i] <= s2[i];
                    fall_q[i] <= ~s2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.db_out = db;
    assign bus.rise   = rise_q;
    assign bus.fall   = fall_q;
endmodule

// File: tb/tb_sw_conditioner.sv
// Scoreboard bench: a window-based reference model predicts every cycle's outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_sw_conditioner;
    localparam int N  = 3;
    localparam int SC = 4;

    typedef struct packed {
        logic [N-1:0] db;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    sw_conditioner_if #(.N(N)) bus ();

    sw_conditioner #(.N(N), .STABLE_CYCLES(SC), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: sw_in reaches the debouncer two edges late; a channel flips
    // when the last SC delayed samples since reset/flip all differ from its level.
    exp_t         sbq [$];
    logic [N-1:0] syncq [$];
    logic [N-1:0] win [$];
    logic [N-1:0] lvl;

    task automatic model_reset();
        syncq = '{'0, '0};
        win.delete();
        lvl = '0;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        exp_t e;
        logic [N-1:0] s;
        logic all_diff;
        e = '0;
        if (!rst_n) begin
            model_reset();
        end else begin
            s = syncq.pop_front();
            syncq.push_back(bus.sw_in);
            win.push_back(s);
            if (win.size() > SC) void'(win.pop_front());
            for (int i = 0; i < N; i++) begin
                if (win.size() == SC) begin
                    all_diff = 1'b1;
                    foreach (win[k]) if (win[k][i] == lvl[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        lvl[i] = ~lvl[i];
                        if (lvl[i]) e.rise[i] = 1'b1;
                        else        e.fall[i] = 1'b1;
                    end
                end
            end
            e.db = lvl;
        end
        sbq.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL sb_empty t=%0t no expectation queued", $time);
        end else begin
            e = sbq.pop_front();
            if ({bus.db_out, bus.rise, bus.fall} !== {e.db, e.rise, e.fall}) begin
                bad++;
                $display("FAIL sb_cycle t=%0t got db=%b rise=%b fall=%b want db=%b rise=%b fall=%b",
                         $time, bus.db_out, bus.rise, bus.fall, e.db, e.rise, e.fall);
            end
        end
        total++;
        if ((bus.rise & bus.fall) !== '0) begin
            bad++;
            $display("FAIL rise_fall_overlap t=%0t got rise=%b fall=%b want disjoint",
                     $time, bus.rise, bus.fall);
        end
    end

    task automatic hold(input logic [N-1:0] v, input int n);
        bus.sw_in = v;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.db_out, bus.rise, bus.fall} !== '0) begin
            bad++;
            $display("FAIL async_reset t=%0t got db=%b rise=%b fall=%b want all 0",
                     $time, bus.db_out, bus.rise, bus.fall);
        end
        repeat (n) begin
            @(negedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.sw_in = '0;
        // reset held while switches toggle, then quiet release
        for (int i = 0; i < 6; i++) hold(N'($urandom_range(0, 7)), 1);
        bus.sw_in = '0;
        rst_n = 1'b1;
        hold(3'b000, 50);
        // clean step on channel 0
        hold(3'b001, 12);
        // bounce on channel 1 then settle high
        hold(3'b011, 1); hold(3'b001, 1); hold(3'b011, 1); hold(3'b001, 1);
        hold(3'b011, 12);
        // three-cycle glitch on channel 2
        hold(3'b111, 3);
        hold(3'b011, 12);
        // simultaneous edges
        hold(3'b000, 12);
        hold(3'b111, 12);
        hold(3'b000, 12);
        // reset mid-debounce, and reset while levels are high
        hold(3'b001, 5);
        do_reset(2);
        hold(3'b001, 12);
        hold(3'b111, 12);
        do_reset(1);
        hold(3'b111, 12);
        // randomized runs with occasional reset
        for (int r = 0; r < 120; r++) begin
            if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
            hold(N'($urandom_range(0, 7)), $urandom_range(1, 8));
        end
        hold(bus.sw_in, 10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
